// File: rtl/matrix_multiplier2x2.sv
// matrix_multiplier2x2
//   Outer-product style 2x2 multiplier built from four identical processing
//   elements (PEs) arranged 1x4. Each PE registers the full 16-bit unsigned
//   product of one x operand and one y operand, with one clock of latency.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : synchronous active-high reset, clears all products
//   x0, x1       : 8-bit unsigned row operands
//   y0, y1       : 8-bit unsigned column operands
//   p0 .. p3     : 16-bit registered products x0*y0, x1*y0, x0*y1, x1*y1
module matrix_multiplier2x2 (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  x0,
    input  logic [7:0]  x1,
    input  logic [7:0]  y0,
    input  logic [7:0]  y1,
    output logic [15:0] p0,
    output logic [15:0] p1,
    output logic [15:0] p2,
    output logic [15:0] p3
);

    localparam int unsigned NumPe = 4;

    logic [7:0]  w_x [NumPe];
    logic [7:0]  w_y [NumPe];
    logic [15:0] r_p [NumPe];

    // PE operand routing: PE0 (x0,y0), PE1 (x1,y0), PE2 (x0,y1), PE3 (x1,y1)
    assign w_x[0] = x0;
    assign w_y[0] = y0;
    assign w_x[1] = x1;
    assign w_y[1] = y0;
    assign w_x[2] = x0;
    assign w_y[2] = y1;
    assign w_x[3] = x1;
    assign w_y[3] = y1;

    for (genvar g = 0; g < NumPe; g++) begin : g_pe
        // Operands widened before multiplying so no product bit is lost.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_p[g] <= 16'd0;
            end else begin
                r_p[g] <= 16'(w_x[g]) * 16'(w_y[g]);
            end
        end
    end

    assign p0 = r_p[0];
    assign p1 = r_p[1];
    assign p2 = r_p[2];
    assign p3 = r_p[3];

endmodule

// File: tb/tb_matrix_multiplier2x2.sv
module tb_matrix_multiplier2x2;

    logic        clk;
    logic        rst;
    logic [7:0]  x0, x1, y0, y1;
    logic [15:0] p0, p1, p2, p3;

    int checks = 0;
    int errors = 0;

    // Scoreboard of expected {p0,p1,p2,p3}, pushed when stimulus is driven.
    logic [63:0] sb_q [$];

    matrix_multiplier2x2 dut (
        .clk (clk),
        .rst (rst),
        .x0  (x0),
        .x1  (x1),
        .y0  (y0),
        .y1  (y1),
        .p0  (p0),
        .p1  (p1),
        .p2  (p2),
        .p3  (p3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] e);
        check({tag, ".p0"}, p0, e[63:48]);
        check({tag, ".p1"}, p1, e[47:32]);
        check({tag, ".p2"}, p2, e[31:16]);
        check({tag, ".p3"}, p3, e[15:0]);
    endtask

    // Drive one set of inputs, queue the expectation, clock once, then compare.
    task automatic step(input string tag, input logic r,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] b0, input logic [7:0] b1,
                        input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] e3);
        logic [63:0] exp;
        rst = r;
        x0  = a0;
        x1  = a1;
        y0  = b0;
        y1  = b1;
        sb_q.push_back({e0, e1, e2, e3});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            exp = sb_q.pop_front();
            check_all(tag, exp);
        end
    endtask

    initial begin
        logic [7:0]  ra0, ra1, rb0, rb1;
        logic [15:0] m0, m1, m2, m3;

        rst = 1'b1;
        x0  = 8'd0;
        x1  = 8'd0;
        y0  = 8'd0;
        y1  = 8'd0;

        step("reset",    1'b1, 8'd0,   8'd0,   8'd0,   8'd0,   16'd0,  16'd0,  16'd0,  16'd0);
        step("basic",    1'b0, 8'd8,   8'd2,   8'd4,   8'd3,   16'd32, 16'd8,  16'd24, 16'd6);
        step("no_accum", 1'b0, 8'd10,  8'd5,   8'd2,   8'd6,   16'd20, 16'd10, 16'd60, 16'd30);
        step("by_one",   1'b0, 8'd255, 8'd255, 8'd1,   8'd1,
             16'd255, 16'd255, 16'd255, 16'd255);
        step("max",      1'b0, 8'd255, 8'd255, 8'd255, 8'd255,
             16'd65025, 16'd65025, 16'd65025, 16'd65025);

        // Operand changes between edges must not reach the outputs.
        x0 = 8'd1;
        x1 = 8'd2;
        y0 = 8'd3;
        y1 = 8'd4;
        #2;
        check_all("midcycle_hold", {16'd65025, 16'd65025, 16'd65025, 16'd65025});

        // Reset raised between edges has no effect until the next edge.
        rst = 1'b1;
        #1;
        check_all("async_rst_hold", {16'd65025, 16'd65025, 16'd65025, 16'd65025});

        step("rst_mid",  1'b1, 8'd3,   8'd7,   8'd9,   8'd11,  16'd0,  16'd0,  16'd0,  16'd0);
        step("release",  1'b0, 8'd3,   8'd7,   8'd9,   8'd11,  16'd27, 16'd63, 16'd33, 16'd77);
        step("zeros",    1'b0, 8'd0,   8'd200, 8'd0,   8'd17,  16'd0,  16'd0,  16'd0,  16'd3400);

        for (int i = 0; i < 6; i++) begin
            ra0 = 8'($urandom_range(0, 255));
            ra1 = 8'($urandom_range(0, 255));
            rb0 = 8'($urandom_range(0, 255));
            rb1 = 8'($urandom_range(0, 255));
            m0  = 16'(int'(ra0) * int'(rb0));
            m1  = 16'(int'(ra1) * int'(rb0));
            m2  = 16'(int'(ra0) * int'(rb1));
            m3  = 16'(int'(ra1) * int'(rb1));
            step("random", 1'b0, ra0, ra1, rb0, rb1, m0, m1, m2, m3);
        end

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
